pb_cmd_debounce: RTL and testbench

- Upstream front end for the stopwatch mode FSM.
- Takes raw, bouncy push-button levels and synchronizes them, then debounces each button independently.
- Converts each accepted press into a single-cycle, one-hot command pulse with a valid strobe.
- Replaces the simple OR/two-flop strobe path so the FSM sees exactly one clean event per physical press.

---
 rtl/pb_cmd_debounce_pkg.sv | 37 +++
 rtl/pb_cmd_debounce_if.sv | 26 ++
 rtl/pb_cmd_debounce_btn.sv | 144 ++++++++++++++
 rtl/pb_cmd_debounce.sv | 69 ++++++
 tb/tb_pb_cmd_debounce.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pb_cmd_debounce_pkg.sv
// Shared types and helpers for the stopwatch push-button front end.
// Button FSM states, mode-FSM command codes and small bit-vector helpers.
package pb_cmd_debounce_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE       = 2'd0,
    BTN_DB_PRESS   = 2'd1,
    BTN_PRESSED    = 2'd2,
    BTN_DB_RELEASE = 2'd3
  } btn_state_t;

  // Mode FSM encoding; cmd bit i maps straight onto the matching keyout code.
  typedef enum logic [2:0] {
    MODE_RUNNING = 3'b001,
    MODE_CLEAR   = 3'b010,
    MODE_IDLE    = 3'b100
  } state_t;

  localparam logic [2:0] CMD_RUNNING = 3'b001;
  localparam logic [2:0] CMD_CLEAR   = 3'b010;
  localparam logic [2:0] CMD_IDLE    = 3'b100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [31:0] lowest_one(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

  function automatic logic is_multi(input logic [31:0] v);
    return |(v & (v - 32'd1));
  endfunction

endpackage

// File: rtl/pb_cmd_debounce_if.sv
// Button/command bundle between the raw button pins, this front end and the mode FSM.
interface pb_cmd_debounce_if #(
  parameter int NBTN = 3
);
  logic [NBTN-1:0] i_pb;
  logic [NBTN-1:0] o_cmd;
  logic            o_cmd_valid;
  logic [NBTN-1:0] o_level;
  logic            o_collision;

  modport master (
    output i_pb,
    input  o_cmd,
    input  o_cmd_valid,
    input  o_level,
    input  o_collision
  );

  modport slave (
    input  i_pb,
    output o_cmd,
    output o_cmd_valid,
    output o_level,
    output o_collision
  );
endinterface

// File: rtl/pb_cmd_debounce_btn.sv
// Single-button synchronizer + debounce FSM; emits a debounced level and an event pulse.
// Auto-repeat hold counter exists only when PB_CMD_AUTOREPEAT_EN is defined.
module btn_debounce
  import pb_cmd_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
`ifdef PB_CMD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 20
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pb,
  output logic o_level,
  output logic o_event
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  btn_state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic       r_level;
  logic       w_s;
  logic       w_press_evt;

  assign w_s         = r_sync2;
  assign w_press_evt = (r_state == BTN_DB_PRESS) && w_s && (r_cnt == CNT_LAST);
  assign o_level     = r_level;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pb;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM: both press and release need DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= BTN_IDLE;
      r_cnt   <= CNT_ZERO;
      r_level <= 1'b0;
    end else begin
      case (r_state)
        BTN_IDLE: begin
          if (w_s) begin
            r_state <= BTN_DB_PRESS;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= BTN_IDLE;
            r_cnt   <= CNT_ZERO;
          end
        end
        BTN_DB_PRESS: begin
          if (!w_s) begin
            r_state <= BTN_IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= BTN_PRESSED;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        BTN_PRESSED: begin
          if (!w_s) begin
            r_state <= BTN_DB_RELEASE;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= BTN_PRESSED;
            r_cnt   <= CNT_ZERO;
          end
        end
        BTN_DB_RELEASE: begin
          // A high sample here is release bounce: back to PRESSED without a new event.
          if (w_s) begin
            r_state <= BTN_PRESSED;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= BTN_IDLE;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= BTN_IDLE;
          r_cnt   <= CNT_ZERO;
          r_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef PB_CMD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] r_hold;
  logic             r_rep_phase;
  logic             w_rep_evt;

  assign w_rep_evt = (r_state == BTN_PRESSED) && w_s &&
                     (r_hold == (r_rep_phase ? HOLD_NEXT : HOLD_FIRST));
  assign o_event   = w_press_evt | w_rep_evt;

  // Hold counter: cleared on the fall into DB_RELEASE, kept across a bounce back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold      <= CNT_ZERO;
      r_rep_phase <= 1'b0;
    end else if (r_state == BTN_PRESSED) begin
      if (!w_s) begin
        r_hold      <= CNT_ZERO;
        r_rep_phase <= 1'b0;
      end else if (w_rep_evt) begin
        r_hold      <= CNT_ZERO;
        r_rep_phase <= 1'b1;
      end else begin
        r_hold      <= r_hold + CNT_ONE;
      end
    end else begin
      r_hold      <= r_hold;
      r_rep_phase <= r_rep_phase;
    end
  end
`else
  assign o_event = w_press_evt;
`endif

endmodule

// File: rtl/pb_cmd_debounce.sv
// Push-button front end: per-button debounce, lowest-index priority encode, sticky collision.
// Optional auto-repeat on held buttons is enabled by defining PB_CMD_AUTOREPEAT_EN.
module pb_cmd_debounce
  import pb_cmd_debounce_pkg::*;
#(
  parameter int NBTN            = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pb_cmd_debounce_if.slave bus
);

  logic [NBTN-1:0] w_event;
  logic [NBTN-1:0] w_level;
  logic [NBTN-1:0] w_onehot;
  logic            w_multi;
  logic [NBTN-1:0] r_cmd;
  logic            r_cmd_valid;
  logic            r_collision;

  if (DEBOUNCE_CYCLES < 2 || NBTN < 1 || NBTN > 32 || REPEAT_PERIOD < 1 || REPEAT_DELAY < 1 ||
      max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) > (2 ** CNT_W) - 1) begin : g_cfg_err
    $error("pb_cmd_debounce: illegal parameter combination");
  end

  for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef PB_CMD_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_btn (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_pb    (bus.i_pb[gi]),
      .o_level (w_level[gi]),
      .o_event (w_event[gi])
    );
  end

  assign w_onehot = NBTN'(lowest_one(32'(w_event)));
  assign w_multi  = is_multi(32'(w_event));

  // Registered command strobe; losing simultaneous events are dropped but flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd       <= {NBTN{1'b0}};
      r_cmd_valid <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_cmd       <= w_onehot;
      r_cmd_valid <= |w_event;
      r_collision <= r_collision | w_multi;
    end
  end

  assign bus.o_cmd       = r_cmd;
  assign bus.o_cmd_valid = r_cmd_valid;
  assign bus.o_collision = r_collision;
  assign bus.o_level     = w_level;

endmodule

// File: tb/tb_pb_cmd_debounce.sv
// Randomized + directed bench for pb_cmd_debounce against a run-length reference model.
module tb_pb_cmd_debounce;

  localparam int NB     = 3;
  localparam int DC     = 4;
  localparam int DELAY  = 50;
  localparam int PERIOD = 20;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  pb_cmd_debounce_if #(.NBTN(NB)) u_if ();

  pb_cmd_debounce #(
    .NBTN            (NB),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (8),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: raw-sample history, accepted level, run length, hold time.
  logic [NB-1:0] m_p1, m_p2, m_prev, m_lvl, e_cmd;
  logic          e_valid, e_col;
  int            m_run  [NB];
  int            m_hold [NB];
  int            seg_cyc, pulses, first_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [NB-1:0] p, input logic r);
    logic [NB-1:0] s, ev;
    int k;
    if (r) begin
      m_p1 = '0; m_p2 = '0; m_prev = '0; m_lvl = '0;
      e_cmd = '0; e_valid = 1'b0; e_col = 1'b0;
      for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_hold[i] = 0; end
    end else begin
      s  = m_p2;
      ev = '0;
      for (int i = 0; i < NB; i++) begin
`ifdef PB_CMD_AUTOREPEAT_EN
        if (m_lvl[i] && m_prev[i] && s[i]) begin
          m_hold[i]++;
          if (m_hold[i] == DELAY || (m_hold[i] > DELAY && (m_hold[i] - DELAY) % PERIOD == 0))
            ev[i] = 1'b1;
        end else if (m_lvl[i] && !s[i]) begin
          m_hold[i] = 0;
        end
`endif
        if (s[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_lvl[i] = s[i];
            m_run[i] = 0;
            if (s[i]) ev[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_prev = s;
      m_p2   = m_p1;
      m_p1   = p;
      e_valid = |ev;
      e_cmd   = '0;
      k = 0;
      for (int i = NB - 1; i >= 0; i--) begin
        if (ev[i]) begin
          e_cmd = NB'(1) << i;
          k++;
        end
      end
      if (k >= 2) e_col = 1'b1;
    end
  endtask

  task automatic tick(input logic [NB-1:0] p, input logic r);
    @(negedge clk);
    u_if.i_pb = p;
    rst = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
    chk("cmd",   32'(u_if.o_cmd),       32'(e_cmd));
    chk("valid", 32'(u_if.o_cmd_valid), 32'(e_valid));
    chk("level", 32'(u_if.o_level),     32'(m_lvl));
    chk("coll",  32'(u_if.o_collision), 32'(e_col));
    if (u_if.o_cmd_valid === 1'b1) begin
      pulses++;
      if (first_at < 0) first_at = seg_cyc;
    end
    seg_cyc++;
  endtask

  task automatic seg_start();
    seg_cyc = 0; pulses = 0; first_at = -1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick('0, 1'b1);
  endtask

  logic [NB-1:0] rnd_pb;

  initial begin
    n_total = 0; n_bad = 0;
    rst = 1'b1;
    u_if.i_pb = '0;
    model_edge('0, 1'b1);

    // Reset held with all buttons pressed, then release with buttons still held
    for (int i = 0; i < 3; i++) tick(3'b111, 1'b1);
    chk("rst_cmd", 32'(u_if.o_cmd), 32'd0);
    seg_start();
    for (int i = 0; i < 12; i++) tick(3'b111, 1'b0);
    chk("rst_at", 32'(first_at), 32'd5);
    chk("rst_pulses", 32'(pulses), 32'd1);
    chk("rst_coll", 32'(u_if.o_collision), 32'd1);

    // Clean press on button 1
    do_reset(2);
    seg_start();
    for (int i = 0; i < 30; i++) tick(3'b010, 1'b0);
    chk("press_at", 32'(first_at), 32'd5);
    chk("press_pulses", 32'(pulses), 32'd1);
    for (int i = 0; i < 10; i++) tick(3'b000, 1'b0);

    // Bounce rejection on button 0
    seg_start();
    for (int i = 0; i < 20; i++) tick((i % 4 == 3) ? 3'b000 : 3'b001, 1'b0);
    for (int i = 0; i < 10; i++) tick(3'b000, 1'b0);
    chk("bounce_pulses", 32'(pulses), 32'd0);

    // Release bounce on button 2
    seg_start();
    for (int i = 0; i < 10; i++) tick(3'b100, 1'b0);
    tick(3'b000, 1'b0); tick(3'b000, 1'b0); tick(3'b100, 1'b0);
    for (int i = 0; i < 10; i++) tick(3'b000, 1'b0);
    chk("relb_pulses", 32'(pulses), 32'd1);
    chk("relb_level", 32'(u_if.o_level), 32'd0);

    // Simultaneous press: lowest index wins, collision sticky until reset
    do_reset(2);
    seg_start();
    for (int i = 0; i < 3; i++) tick(3'b000, 1'b0);
    for (int i = 0; i < 10; i++) tick(3'b101, 1'b0);
    for (int i = 0; i < 10; i++) tick(3'b000, 1'b0);
    chk("sim_pulses", 32'(pulses), 32'd1);
    chk("sim_coll", 32'(u_if.o_collision), 32'd1);
    do_reset(1);
    chk("sim_coll_clr", 32'(u_if.o_collision), 32'd0);

`ifdef PB_CMD_AUTOREPEAT_EN
    seg_start();
    for (int i = 0; i < 120; i++) tick(3'b001, 1'b0);
    for (int i = 0; i < 20; i++) tick(3'b000, 1'b0);
    chk("rep_pulses", 32'(pulses), 32'd5);
`endif

    // Randomized bouncy stimulus with occasional resets
    rnd_pb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 9) == 0) rnd_pb[b] = ~rnd_pb[b];
      tick(rnd_pb, ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
